run_detector: RTL and testbench
===============================

# run_detector

Parametrised run-length detector for a serial bit stream. It generalises the fixed four-in-a-row detector to a configurable run length, a sample-enable strobe, a polarity mode, and a saturating match counter. It sits between a debounced/synchronised input bit and downstream status logic or LEDs. The z output remains a Moore output, decoded from registered state only.

## Interface
- RUN_LEN, 4: consecutive equal samples required for a match; legal range 2..255.
- CNT_W, $clog2(RUN_LEN+1): width of run_cnt; derived, not overridden.
- HIT_W, 8: width of hits counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- en  in  1  sample strobe; w is sampled only when en=1.
- w  in  1  serial data bit.
- mode  in  2  00 both polarities, 01 ones only, 10 zeros only, 11 z masked.
- clr_hits  in  1  synchronous clear of hits.
- z  out  1  match: current run length equals RUN_LEN and mode permits the run polarity.
- z_sym  out  1  polarity of the current run (0 = zeros, 1 = ones); 0 in IDLE.
- run_cnt  out  CNT_W  length of the current run, saturating at RUN_LEN.
- hits  out  HIT_W  number of match entries since reset/clear, saturating at all-ones.

## Operation
- State: sym_state ∈ {IDLE, ZEROS, ONES}, plus run_cnt.
- Reset (reset_n=0 at an edge): sym_state=IDLE, run_cnt=0, hits=0. Therefore z=0 and z_sym=0. Reset overrides all other inputs.
- en=0: sym_state and run_cnt hold; hits changes only via clr_hits.
- en=1 in IDLE: go to ZEROS if w=0, ONES if w=1; run_cnt=1.
- en=1 with w equal to the current run polarity: stay; run_cnt = min(run_cnt+1, RUN_LEN). Runs overlap, so z stays high for every further equal sample.
- en=1 with w opposite to the current run polarity: switch to the other state; run_cnt=1.
- z = (run_cnt==RUN_LEN) & permitted(mode, sym_state).
  - permitted is true for ZEROS when mode ∈ {00,10}.
  - permitted is true for ONES when mode ∈ {00,01}.
  - permitted is false for mode 11.
- Match entry: at an edge where the next z = 1 and the current z = 0. On a match entry, hits increments unless it is already all-ones.
- mode is combinational into z. A mode change while run_cnt==RUN_LEN can raise z without a new sample, and that rise counts as a match entry.
- Simultaneous clr_hits and match entry: hits=1. clr_hits alone: hits=0.
- Run counting continues in mode 11; only z and hit counting are masked.

## Timing
- Latency: z rises in the cycle after the edge that registers the RUN_LEN-th consecutive equal sample with en=1.
- z falls in the cycle after the edge that registers an opposite sample.
- All outputs come from registers or from registers decoded with mode. There is no combinational path from w or en to any output.
- Reset mid-run: outputs return to reset values the cycle after the reset edge. The next sample starts a new run with run_cnt=1.

## Structure
- Shared package run_det_pkg:
  - sym_state encoding: IDLE=2'b00, ZEROS=2'b01, ONES=2'b10.
  - mode constants: MODE_BOTH, MODE_ONES, MODE_ZEROS, MODE_OFF.
- Sub-module sat_counter, parameter W; inputs clr, load1, inc; output q saturating at a max value.
  - Instantiated twice: run_cnt with max RUN_LEN, hits with max all-ones.
  - clr and inc asserted together give q=1.
- Top level holds the sym_state register, next-state logic, permitted/z decode, and match-entry detect.

## Test plan
- RUN_LEN=4, mode=00, en=1, w=0,0,0,0,0,1: z=0,0,0,1,1,0 (each value one cycle after its sample); hits=1; run_cnt=1,2,3,4,4,1.
- mode=01, w=0×5 then 1×4: z stays 0 through the zeros, then goes to 1 after the 4th one with z_sym=1; hits=1.
- en toggling: w=1 with en=1,0,1,0,1,1 gives z=1 only after the 4th enabled sample; run_cnt holds on en=0 cycles.
- HIT_W=2: produce 5 separate matches → hits=1,2,3,3,3. Then clr_hits concurrent with a 6th match entry → hits=1.
- Reset mid-run: after 3 ones, assert reset_n=0 for one edge, then w=1×3 → z=0, run_cnt=3; a 4th one gives z=1.
- mode change: hold run at run_cnt=4 with mode=11 (z=0), switch mode to 00 with en=0 → z=1 in the same cycle, hits increments by 1.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types and constants for the run-length detector.
//   sym_state_t : polarity of the run being tracked (IDLE / ZEROS / ONES)
//   MODE_*      : polarity mask applied to the match output
//   permitted() : whether a given mode lets a run of the given polarity match
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ZEROS = 2'b01,
    ONES  = 2'b10
  } sym_state_t;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  function automatic logic permitted(input logic [1:0] mode, input sym_state_t s);
    case (s)
      ZEROS:   return (mode == MODE_BOTH) || (mode == MODE_ZEROS);
      ONES:    return (mode == MODE_BOTH) || (mode == MODE_ONES);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// Signal bundle between the sample source / status consumer and run_detector.
//   en, w, mode, clr_hits : sample strobe, data bit, polarity mode, hit clear
//   z, z_sym, run_cnt, hits : match flag, run polarity, run length, match count
// master drives the inputs and observes status; slave is the detector.
interface run_detector_if #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned HIT_W   = 8
);
  localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);

  logic             en;
  logic             w;
  logic [1:0]       mode;
  logic             clr_hits;
  logic             z;
  logic             z_sym;
  logic [CNT_W-1:0] run_cnt;
  logic [HIT_W-1:0] hits;

  modport master (
    output en, w, mode, clr_hits,
    input  z, z_sym, run_cnt, hits
  );

  modport slave (
    input  en, w, mode, clr_hits,
    output z, z_sym, run_cnt, hits
  );
endinterface

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
//   clr   : force to 0 (to 1 if inc is also asserted)
//   load1 : force to 1
//   inc   : increment, holding at MAX
//   q     : counter value
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// Run-length detector for a serial bit stream.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : en/w sample input, mode polarity mask, clr_hits;
//                  z match flag (Moore, masked by mode), z_sym run polarity,
//                  run_cnt saturating run length, hits saturating match count
module run_detector
  import run_det_pkg::*;
#(
  parameter  int unsigned RUN_LEN = 4,
  parameter  int unsigned HIT_W   = 8,
  localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  run_detector_if.slave   bus
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  sym_state_t       sym_state;
  sym_state_t       sym_next;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [HIT_W-1:0] hits;
  logic             cnt_load1;
  logic             cnt_inc;
  logic             z_now;
  logic             z_next;
  logic             z_acc;
  logic             hit_entry;

  // sym_next is never IDLE, so a change of state covers both the first
  // sample after IDLE and a polarity flip.
  always_comb begin
    sym_next  = sym_state;
    cnt_next  = run_cnt;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    if (bus.en) begin
      sym_next = bus.w ? ONES : ZEROS;
      if (sym_next != sym_state) begin
        cnt_load1 = 1'b1;
        cnt_next  = CNT_W'(1);
      end else begin
        cnt_inc = 1'b1;
        if (run_cnt != RUN_MAX) cnt_next = run_cnt + CNT_W'(1);
      end
    end
  end

  assign z_now  = (run_cnt == RUN_MAX) && permitted(bus.mode, sym_state);
  assign z_next = (cnt_next == RUN_MAX) && permitted(bus.mode, sym_next);

  // z_acc remembers the z value already accounted for at the last edge
  // (evaluated with the mode of that cycle). Comparing against it rather
  // than the live z makes a mode-driven rise of z count exactly once, at
  // the following edge, while sample-driven rises count at their own edge.
  assign hit_entry = z_next && !z_acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_state <= IDLE;
      z_acc     <= 1'b0;
    end else begin
      sym_state <= sym_next;
      z_acc     <= z_next;
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX (RUN_MAX)
  ) u_run_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .load1   (cnt_load1),
    .inc     (cnt_inc),
    .q       (run_cnt)
  );

  sat_counter #(
    .W   (HIT_W),
    .MAX ('1)
  ) u_hits (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clr_hits),
    .load1   (1'b0),
    .inc     (hit_entry),
    .q       (hits)
  );

  assign bus.z       = z_now;
  assign bus.z_sym   = (sym_state == ONES);
  assign bus.run_cnt = run_cnt;
  assign bus.hits    = hits;

endmodule

// File: tb/tb_run_detector.sv
module tb_run_detector;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  run_detector_if #(.RUN_LEN(4), .HIT_W(2)) bus ();

  run_detector #(.RUN_LEN(4), .HIT_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic e, input logic b);
    bus.en = e;
    bus.w  = b;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.en = 1'b0;
    bus.clr_hits = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic       t1_w   [6] = '{0, 0, 0, 0, 0, 1};
    logic       t1_z   [6] = '{0, 0, 0, 1, 1, 0};
    logic       t1_sym [6] = '{0, 0, 0, 0, 0, 1};
    int         t1_cnt [6] = '{1, 2, 3, 4, 4, 1};
    int         t1_hit [6] = '{0, 0, 0, 1, 1, 1};
    logic       t3_en  [6] = '{1, 0, 1, 0, 1, 1};
    int         t3_cnt [6] = '{1, 1, 2, 2, 3, 4};
    logic       t3_z   [6] = '{0, 0, 0, 0, 0, 1};
    int         t4_hit [5] = '{1, 2, 3, 3, 3};

    reset_n = 1'b0;
    bus.en = 1'b0;
    bus.w = 1'b0;
    bus.mode = 2'b00;
    bus.clr_hits = 1'b0;
    tick();
    tick();
    chk("rst_z", bus.z, 0);
    chk("rst_zsym", bus.z_sym, 0);
    chk("rst_cnt", bus.run_cnt, 0);
    chk("rst_hits", bus.hits, 0);
    reset_n = 1'b1;

    // basic run of zeros then a flip, both polarities
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, t1_w[i]);
      chk($sformatf("t1_z%0d", i), bus.z, t1_z[i]);
      chk($sformatf("t1_cnt%0d", i), bus.run_cnt, t1_cnt[i]);
      chk($sformatf("t1_sym%0d", i), bus.z_sym, t1_sym[i]);
      chk($sformatf("t1_hit%0d", i), bus.hits, t1_hit[i]);
    end

    // ones-only mode: zeros never match
    do_reset();
    bus.mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      sample(1'b1, 1'b0);
      chk($sformatf("t2_z0_%0d", i), bus.z, 0);
    end
    chk("t2_cnt0", bus.run_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 1'b1);
      chk($sformatf("t2_z1_%0d", i), bus.z, (i == 3) ? 1 : 0);
    end
    chk("t2_sym", bus.z_sym, 1);
    chk("t2_hits", bus.hits, 1);

    // sample strobe gating
    do_reset();
    bus.mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      sample(t3_en[i], 1'b1);
      chk($sformatf("t3_cnt%0d", i), bus.run_cnt, t3_cnt[i]);
      chk($sformatf("t3_z%0d", i), bus.z, t3_z[i]);
    end

    // hits saturation with HIT_W=2, then clear concurrent with an entry
    do_reset();
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) sample(1'b1, 1'b1);
      chk($sformatf("t4_z%0d", m), bus.z, 1);
      chk($sformatf("t4_hit%0d", m), bus.hits, t4_hit[m]);
      sample(1'b1, 1'b0);
      chk($sformatf("t4_zoff%0d", m), bus.z, 0);
    end
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
    bus.clr_hits = 1'b1;
    sample(1'b1, 1'b1);
    bus.clr_hits = 1'b0;
    chk("t4_clr_entry", bus.hits, 1);
    bus.clr_hits = 1'b1;
    sample(1'b0, 1'b1);
    bus.clr_hits = 1'b0;
    chk("t4_clr_only", bus.hits, 0);
    chk("t4_z_hold", bus.z, 1);

    // reset in the middle of a run
    do_reset();
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
    chk("t5_pre_cnt", bus.run_cnt, 3);
    reset_n = 1'b0;
    sample(1'b1, 1'b1);
    chk("t5_rst_cnt", bus.run_cnt, 0);
    chk("t5_rst_sym", bus.z_sym, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
    chk("t5_cnt3", bus.run_cnt, 3);
    chk("t5_z3", bus.z, 0);
    sample(1'b1, 1'b1);
    chk("t5_z4", bus.z, 1);

    // mode change with a saturated run raises z and counts once
    do_reset();
    bus.mode = 2'b11;
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b1);
    chk("t6_cnt", bus.run_cnt, 4);
    chk("t6_z_off", bus.z, 0);
    chk("t6_hits0", bus.hits, 0);
    bus.en = 1'b0;
    bus.mode = 2'b00;
    #1;
    chk("t6_z_comb", bus.z, 1);
    chk("t6_hits_pre", bus.hits, 0);
    tick();
    chk("t6_hits1", bus.hits, 1);
    tick();
    chk("t6_hits_hold", bus.hits, 1);
    bus.mode = 2'b10;
    #1;
    chk("t6_z_zeros_mode", bus.z, 0);
    tick();
    bus.mode = 2'b00;
    #1;
    chk("t6_z_back", bus.z, 1);
    tick();
    chk("t6_hits2", bus.hits, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
